// File: rtl/gelu_poly_scheduler_if.sv
// Request, PolynomialUnit and response signals of gelu_poly_scheduler, bundled as one interface.
interface gelu_poly_scheduler_if #(
  parameter int W     = 32,
  parameter int N_REQ = 2
) ();
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               pu_valid_in;
  logic [W-1:0]       pu_xi_q;
  logic               pu_valid_out;
  logic [W-1:0]       pu_s_xi_q;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ*W-1:0] rsp_data;
  logic [N_REQ-1:0]   rsp_last;
  logic [N_REQ-1:0]   rsp_ready;
  logic               busy;
  logic               err_sync;

  modport slave (
    input  req_valid, req_data, req_last, pu_valid_out, pu_s_xi_q, rsp_ready,
    output req_ready, pu_valid_in, pu_xi_q, rsp_valid, rsp_data, rsp_last, busy, err_sync
  );

  modport master (
    output req_valid, req_data, req_last, pu_valid_out, pu_s_xi_q, rsp_ready,
    input  req_ready, pu_valid_in, pu_xi_q, rsp_valid, rsp_data, rsp_last, busy, err_sync
  );
endinterface

// File: rtl/gelu_poly_scheduler.sv
// Shares one fixed-latency GELU PolynomialUnit among N_REQ requesters: burst-locked round-robin
// grant, latency-matched tag pipe steering results into per-requester credit-protected FIFOs.
module gelu_poly_scheduler #(
  parameter int W          = 32,
  parameter int N_REQ      = 2,
  parameter int LAT        = 7,
  parameter int FIFO_DEPTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  gelu_poly_scheduler_if.slave bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_grant, w_grant_nxt, r_rr_ptr, w_rr_nxt, w_sel, w_idx;
  logic [IDW:0]     w_sum;
  logic             w_hit, w_cand, w_grant_ok, w_accept, w_fifo_any;
  logic [N_REQ-1:0] w_acc_vec, w_push, w_pop;
  logic [CW-1:0]    r_credit [N_REQ];
  logic [CW-1:0]    r_count  [N_REQ];
  logic [AW-1:0]    r_rd_ptr [N_REQ];
  logic [AW-1:0]    r_wr_ptr [N_REQ];
  logic [W-1:0]     r_mem      [N_REQ][FIFO_DEPTH];
  logic             r_mem_last [N_REQ][FIFO_DEPTH];
  logic [LAT-1:0]   r_tag_v, r_tag_last;
  logic [IDW-1:0]   r_tag_id [LAT];
  logic             r_err;

  // Round-robin search from r_rr_ptr; iterating downward lets the nearest candidate win.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_sum = '0;
    w_idx = '0;
    w_cand = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum  = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      w_idx  = (w_sum >= (IDW+1)'(N_REQ)) ? IDW'(w_sum - (IDW+1)'(N_REQ)) : w_sum[IDW-1:0];
      w_cand = bus.req_valid[w_idx] && (r_credit[w_idx] != '0);
      w_sel  = w_cand ? w_idx : w_sel;
      w_hit  = w_hit | w_cand;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_grant_ok  = (r_credit[r_grant] != '0);
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_state_nxt = LOCK;
          w_grant_nxt = w_sel;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOCK: begin
        w_accept = bus.req_valid[r_grant] && w_grant_ok;
        if (w_accept && bus.req_last[r_grant]) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = (r_grant == IDW'(N_REQ - 1)) ? '0 : r_grant + IDW'(1);
        end else begin
          w_state_nxt = LOCK;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake-side outputs are combinational so an accepted beat enters the unit that cycle.
  always_comb begin
    bus.req_ready          = '0;
    bus.req_ready[r_grant] = (r_state == LOCK) && w_grant_ok;
    bus.pu_valid_in        = w_accept;
    bus.pu_xi_q            = w_accept ? bus.req_data[r_grant*W +: W] : '0;
    w_acc_vec              = '0;
    w_acc_vec[r_grant]     = w_accept;
  end

  always_comb begin
    w_fifo_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_push[i]                = r_tag_v[LAT-1] && (r_tag_id[LAT-1] == IDW'(i));
      w_pop[i]                 = (r_count[i] != '0) && bus.rsp_ready[i];
      bus.rsp_valid[i]         = (r_count[i] != '0);
      bus.rsp_data[i*W +: W]   = (r_count[i] != '0) ? r_mem[i][r_rd_ptr[i]] : '0;
      bus.rsp_last[i]          = (r_count[i] != '0) && r_mem_last[i][r_rd_ptr[i]];
      w_fifo_any               = w_fifo_any | (r_count[i] != '0);
    end
    bus.busy     = (r_state == LOCK) | (|r_tag_v) | w_fifo_any;
    bus.err_sync = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Tag pipe mirrors the unit's latency so stage LAT-1 lines up with pu_valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v    <= '0;
      r_tag_last <= '0;
      for (int k = 0; k < LAT; k++) r_tag_id[k] <= '0;
      r_err      <= 1'b0;
    end else begin
      r_tag_v[0]    <= w_accept;
      r_tag_last[0] <= bus.req_last[r_grant];
      r_tag_id[0]   <= r_grant;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]    <= r_tag_v[k-1];
        r_tag_last[k] <= r_tag_last[k-1];
        r_tag_id[k]   <= r_tag_id[k-1];
      end
      if (bus.pu_valid_out != r_tag_v[LAT-1]) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_credit[i] <= CW'(FIFO_DEPTH);
        r_count[i]  <= '0;
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        case ({w_acc_vec[i], w_pop[i]})
          2'b10:   r_credit[i] <= r_credit[i] - CW'(1);
          2'b01:   r_credit[i] <= r_credit[i] + CW'(1);
          default: r_credit[i] <= r_credit[i];
        endcase
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CW'(1);
          2'b01:   r_count[i] <= r_count[i] - CW'(1);
          default: r_count[i] <= r_count[i];
        endcase
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr_ptr[i]]      <= bus.pu_s_xi_q;
        r_mem_last[i][r_wr_ptr[i]] <= r_tag_last[LAT-1];
      end
    end
  end
endmodule

// File: doc/gelu_poly_scheduler.md
Name: gelu_poly_scheduler

Overview:
- Shares one fully pipelined GELU PolynomialUnit (Q26, fixed latency, no back-pressure) among N_REQ streaming requesters.
- Arbitrates bursts round-robin, with the grant locked for the whole burst.
- Tracks in-flight beats with a latency-matched tag pipe and steers each result to its requester's output FIFO.
- Per-requester credit counters guarantee that a result never arrives when its FIFO is full.

Parameters:
- W, 32, data width (Q26 signed fixed point)
- N_REQ, 2, number of requesters (2..4)
- LAT, 7, PolynomialUnit latency in cycles (valid_in edge to valid_out)
- FIFO_DEPTH, 8, result FIFO depth per requester (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  beat valid per requester
- req_data  in  N_REQ*W  xi_q per requester; slice i = [i*W +: W]
- req_last  in  N_REQ  last beat of burst
- req_ready  out  N_REQ  beat accepted when valid&ready
- pu_valid_in  out  1  to PolynomialUnit valid_in
- pu_xi_q  out  W  to PolynomialUnit xi_q
- pu_valid_out  in  1  from PolynomialUnit valid_out
- pu_s_xi_q  in  W  from PolynomialUnit s_xi_q
- rsp_valid  out  N_REQ  result available (show-ahead FIFO head)
- rsp_data  out  N_REQ*W  result per requester
- rsp_last  out  N_REQ  last flag carried with the beat
- rsp_ready  in  N_REQ  result pop
- busy  out  1  grant held, or any tag or FIFO entry non-empty
- err_sync  out  1  sticky: pu_valid_out disagreed with tag-pipe valid

Behaviour:
- Reset (async, rst_n=0):
  - req_ready=0, pu_valid_in=0, pu_xi_q=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, err_sync=0.
  - FSM=IDLE, rr_ptr=0, all tag stages invalid, FIFOs empty, every credit=FIFO_DEPTH.
  - Reset mid-operation discards all in-flight beats. PolynomialUnit shares rst_n, so no stale results return.
- FSM IDLE:
  - Issues nothing; req_ready=0.
  - Selects first i, searching from rr_ptr upward with wrap, such that req_valid[i] and credit[i]>0.
  - On a hit: grant<=i, go to LOCK. Otherwise stay in IDLE.
- FSM LOCK(g):
  - req_ready[g] = (credit[g]>0); all other req_ready=0.
  - On an accepted beat: pu_valid_in=1 and pu_xi_q=req_data[g], both combinational from the handshake.
  - When not accepting: pu_valid_in=0, pu_xi_q=0.
  - Accepted beat with req_last=1: rr_ptr<=g+1 mod N_REQ, go to IDLE (one bubble cycle per burst).
  - req_valid dropping mid-burst: stay in LOCK; grant held until last.
- Tag pipe:
  - LAT-stage shift register of {valid, id, last}. Stage 0 is loaded with {accepted, g, req_last} at the accepting edge.
  - Stage LAT-1 aligns with pu_valid_out.
  - When tag valid: push pu_s_xi_q and last into FIFO[id].
  - pu_valid_out != tag valid: set err_sync (sticky until reset); push only if tag valid.
- Credits:
  - credit[i] decrements on each beat accepted from requester i and increments on each pop (rsp_valid&rsp_ready) from FIFO i.
  - Both in the same cycle: unchanged.
  - Range 0..FIFO_DEPTH; the FIFO can never overflow.
- Latency: a beat accepted at edge t appears with rsp_valid at edge t+LAT+1 if that FIFO was empty.
- Throughput: 1 beat/cycle within a burst while credits last.
- Ordering:
  - Per-requester order is preserved.
  - A requester with rsp_ready=0 stalls only itself. Its credit reaches 0, req_ready falls, and other requesters win later arbitration rounds.
- FIFO full and pop in the same cycle: allowed. A push to a FIFO that is simultaneously popped is legal at any occupancy.

Test Plan:
- Single burst, req0 only: xi={-2.0,-1.0,0.0,1.0} in Q26 (0xF8000000, 0xFC000000, 0, 0x04000000), last on 4th beat, rsp_ready=1.
  - First rsp_valid[0] exactly LAT+1 cycles after first accept.
  - Data within 2 LSB of -2.30220819814*(x+0.044715x³)·2^26; rsp_last on 4th.
- Contention: req0 and req1 both hold 4-beat bursts (req1 xi={0.5,1.5,2.0,2.5}) at the same cycle.
  - req0 is served first, then 1 bubble, then req1.
  - Each FIFO receives only its own results, in order; rr_ptr ends at 0.
- Back-pressure: req0 sends 12 beats with rsp_ready[0]=0.
  - req_ready[0] falls after exactly 8 accepts and FIFO[0] holds 8.
  - Raising rsp_ready[0] drains all 12 with no loss; err_sync=0.
- Fairness: both requesters continuously send 1-beat bursts for 20 grants.
  - Grants alternate 0,1,0,1; each receives 10 results.
- Reset mid-flight: assert rst_n=0 three cycles into a burst.
  - All outputs 0 immediately; credits=FIFO_DEPTH; no rsp_valid after release until new traffic.
- Sync error: force pu_valid_out=1 on a cycle with an empty tag pipe.
  - err_sync=1 next cycle and remains 1; no FIFO push.
